line_scan_check: RTL and testbench

LINE_SCAN_CHECK -- requirements
Module: line_scan_check

---
 rtl/line_scan_check.sv | 230 +++++++++++++++++++++++
 tb/tb_line_scan_check.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_scan_check.sv
// Checks the line of cells through the last-placed piece for a run of WIN_LEN matching pieces.
// Walks the line one board read at a time and reports win and the longest run seen.
module line_scan_check #(
  parameter int unsigned CB      = 4,
  parameter int unsigned WIN_LEN = 5,
  parameter int unsigned RW      = $clog2(WIN_LEN + 1)
) (
  input  logic            i_clk,
  input  logic            i_reset,      // active-low, asynchronous
  input  logic            i_start,
  input  logic [1:0]      i_dir,
  input  logic [2*CB-1:0] i_pointer,
  input  logic [1:0]      i_chess,
  output logic [2*CB-1:0] o_address,
  output logic            o_rd_en,
  input  logic [1:0]      i_rd_data,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_win,
  output logic [RW-1:0]   o_run_max
);

  localparam int unsigned NW = $clog2(2 * WIN_LEN);
  localparam logic [CB-1:0] MAXC = '1;
  localparam logic [CB-1:0] CLIP = CB'(WIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_READ  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_state_n;
  logic [1:0]      r_dir, w_dir_n;
  logic [1:0]      r_chess, w_chess_n;
  logic [CB-1:0]   r_row, w_row_n;
  logic [CB-1:0]   r_col, w_col_n;
  logic [NW-1:0]   r_idx, w_idx_n;
  logic [NW-1:0]   r_last, w_last_n;
  logic [RW-1:0]   r_run, w_run_n;
  logic [RW-1:0]   r_run_max, w_run_max_n;
  logic            r_win, w_win_n;
  logic            r_busy, w_busy_n;
  logic            r_done, w_done_n;
  logic            r_rd_en, w_rd_en_n;

  logic [CB-1:0]   w_back_raw, w_fwd_raw, w_back, w_fwd;
  logic [CB-1:0]   w_first_row, w_first_col, w_step_row, w_step_col;
  logic [RW-1:0]   w_run_inc;

  function automatic logic [CB-1:0] f_min(input logic [CB-1:0] a, input logic [CB-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Line geometry: distance to the board edge each way, clipped to WIN_LEN-1, and unit steps.
  always_comb begin
    w_back_raw  = r_col;
    w_fwd_raw   = MAXC - r_col;
    w_first_row = r_row;
    w_first_col = r_col;
    w_step_row  = r_row;
    w_step_col  = r_col;
    w_back      = '0;
    w_fwd       = '0;
    case (r_dir)
      2'd0: begin
        w_back_raw = r_col;
        w_fwd_raw  = MAXC - r_col;
      end
      2'd1: begin
        w_back_raw = r_row;
        w_fwd_raw  = MAXC - r_row;
      end
      2'd2: begin
        w_back_raw = f_min(r_row, r_col);
        w_fwd_raw  = f_min(MAXC - r_row, MAXC - r_col);
      end
      default: begin
        w_back_raw = f_min(MAXC - r_row, r_col);
        w_fwd_raw  = f_min(r_row, MAXC - r_col);
      end
    endcase
    w_back = f_min(w_back_raw, CLIP);
    w_fwd  = f_min(w_fwd_raw, CLIP);
    case (r_dir)
      2'd0: begin
        w_first_col = r_col - w_back;
        w_step_col  = r_col + CB'(1);
      end
      2'd1: begin
        w_first_row = r_row - w_back;
        w_step_row  = r_row + CB'(1);
      end
      2'd2: begin
        w_first_row = r_row - w_back;
        w_first_col = r_col - w_back;
        w_step_row  = r_row + CB'(1);
        w_step_col  = r_col + CB'(1);
      end
      default: begin
        w_first_row = r_row + w_back;
        w_first_col = r_col - w_back;
        w_step_row  = r_row - CB'(1);
        w_step_col  = r_col + CB'(1);
      end
    endcase
  end

  assign w_run_inc = (i_rd_data == r_chess) ? (r_run + RW'(1)) : '0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_dir     <= '0;
      r_chess   <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_idx     <= '0;
      r_last    <= '0;
      r_run     <= '0;
      r_run_max <= '0;
      r_win     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_dir     <= w_dir_n;
      r_chess   <= w_chess_n;
      r_row     <= w_row_n;
      r_col     <= w_col_n;
      r_idx     <= w_idx_n;
      r_last    <= w_last_n;
      r_run     <= w_run_n;
      r_run_max <= w_run_max_n;
      r_win     <= w_win_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_rd_en   <= w_rd_en_n;
    end
  end

  // Next state and next register values; done/busy/rd_en follow the state being entered.
  always_comb begin
    w_state_n   = r_state;
    w_dir_n     = r_dir;
    w_chess_n   = r_chess;
    w_row_n     = r_row;
    w_col_n     = r_col;
    w_idx_n     = r_idx;
    w_last_n    = r_last;
    w_run_n     = r_run;
    w_run_max_n = r_run_max;
    w_win_n     = r_win;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;
    w_rd_en_n   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_n   = S_SETUP;
          w_dir_n     = i_dir;
          w_chess_n   = i_chess;
          w_row_n     = i_pointer[2*CB-1:CB];
          w_col_n     = i_pointer[CB-1:0];
          w_run_n     = '0;
          w_run_max_n = '0;
          w_win_n     = 1'b0;
          w_busy_n    = 1'b1;
        end
      end
      S_SETUP: begin
        if (r_chess == 2'd0) begin
          w_state_n = S_DONE;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
        end else begin
          w_state_n = S_READ;
          w_row_n   = w_first_row;
          w_col_n   = w_first_col;
          w_idx_n   = '0;
          w_last_n  = NW'(w_back) + NW'(w_fwd);
          w_rd_en_n = 1'b1;
        end
      end
      S_READ: begin
        w_state_n = S_CHECK;
      end
      S_CHECK: begin
        w_run_n = w_run_inc;
        if (w_run_inc > r_run_max) begin
          w_run_max_n = w_run_inc;
        end
        if (w_run_inc == RW'(WIN_LEN)) begin
          w_state_n = S_DONE;
          w_win_n   = 1'b1;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
        end else if (r_idx == r_last) begin
          w_state_n = S_DONE;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
        end else begin
          w_state_n = S_READ;
          w_row_n   = w_step_row;
          w_col_n   = w_step_col;
          w_idx_n   = r_idx + NW'(1);
          w_rd_en_n = 1'b1;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  assign o_address = {r_row, r_col};
  assign o_rd_en   = r_rd_en;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_win     = r_win;
  assign o_run_max = r_run_max;

endmodule

// File: tb/tb_line_scan_check.sv
// Bench for line_scan_check: board memory model, directed scenarios and randomized scans
// checked against a cell-walking reference of the line rules.
module tb_line_scan_check;

  localparam int unsigned CB      = 4;
  localparam int unsigned WIN_LEN = 5;
  localparam int unsigned RW      = $clog2(WIN_LEN + 1);
  localparam int          NSIDE   = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    dir;
  logic [7:0]    pointer;
  logic [1:0]    chess;
  logic [7:0]    address;
  logic          rd_en;
  logic [1:0]    rd_data;
  logic          busy;
  logic          done;
  logic          win;
  logic [RW-1:0] run_max;

  logic [1:0] board [256];
  int         rd_q[$];
  int         exp_q[$];
  bit         exp_win;
  int         exp_rm;
  int         vectors = 0;
  int         errors  = 0;

  line_scan_check #(.CB(CB), .WIN_LEN(WIN_LEN), .RW(RW)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_dir(dir), .i_pointer(pointer),
    .i_chess(chess), .o_address(address), .o_rd_en(rd_en), .i_rd_data(rd_data),
    .o_busy(busy), .o_done(done), .o_win(win), .o_run_max(run_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (rd_en === 1'b1) rd_data <= board[address];
    else                rd_data <= 2'($urandom);
  end

  always @(negedge clk) begin
    if (rd_en === 1'b1) rd_q.push_back(int'(address));
  end

  function automatic bit on_board(input int r, input int c);
    return (r >= 0) && (r < NSIDE) && (c >= 0) && (c < NSIDE);
  endfunction

  function automatic void dir_vec(input logic [1:0] d, output int dr, output int dc);
    case (d)
      2'd0:    begin dr = 0;  dc = 1; end
      2'd1:    begin dr = 1;  dc = 0; end
      2'd2:    begin dr = 1;  dc = 1; end
      default: begin dr = -1; dc = 1; end
    endcase
  endfunction

  // Reference: walk outward cell by cell, then scan the line counting runs.
  task automatic model(input logic [7:0] ptr, input logic [1:0] d, input logic [1:0] c);
    int dr, dc, r0, c0, back, fwd, run, r, cc;
    dir_vec(d, dr, dc);
    r0 = int'(ptr[7:4]);
    c0 = int'(ptr[3:0]);
    back = 0;
    while (back < int'(WIN_LEN) - 1 && on_board(r0 - (back + 1) * dr, c0 - (back + 1) * dc)) back++;
    fwd = 0;
    while (fwd < int'(WIN_LEN) - 1 && on_board(r0 + (fwd + 1) * dr, c0 + (fwd + 1) * dc)) fwd++;
    exp_q.delete();
    exp_win = 1'b0;
    exp_rm  = 0;
    run     = 0;
    if (c != 2'd0) begin
      for (int i = -back; i <= fwd; i++) begin
        r  = r0 + i * dr;
        cc = c0 + i * dc;
        exp_q.push_back(r * NSIDE + cc);
        if (board[r * NSIDE + cc] == c) run++;
        else run = 0;
        if (run > exp_rm) exp_rm = run;
        if (run == int'(WIN_LEN)) begin
          exp_win = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 256; i++) board[i] = 2'd0;
  endtask

  task automatic run_scan(input logic [7:0] ptr, input logic [1:0] d, input logic [1:0] c,
                          input string name, input bit hold_start);
    int cycles, exp_lat, bad;
    logic          held_win;
    logic [RW-1:0] held_rm;
    model(ptr, d, c);
    exp_lat = 2 + 2 * exp_q.size();
    @(posedge clk); #1;
    rd_q.delete();
    start = 1'b1; dir = d; pointer = ptr; chess = c;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    dir = 2'($urandom); pointer = 8'($urandom); chess = 2'($urandom);
    cycles = 1;
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_rise: got %b want 1", name, busy);
    end
    while (done !== 1'b1 && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || cycles != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (done=%b) want %0d", name, cycles, done, exp_lat);
    end
    vectors++;
    if (win !== exp_win) begin
      errors++;
      $display("FAIL %s win: got %b want %b", name, win, exp_win);
    end
    vectors++;
    if (run_max !== RW'(exp_rm)) begin
      errors++;
      $display("FAIL %s run_max: got %0d want %0d", name, run_max, exp_rm);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b want 0", name, busy);
    end
    vectors++;
    bad = -1;
    if (rd_q.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && rd_q[i] != exp_q[i]) bad = i;
    end
    if (rd_q.size() != exp_q.size() || bad >= 0) begin
      errors++;
      $display("FAIL %s reads: got %0d reads (first diff idx %0d) want %0d reads", name,
               rd_q.size(), bad, exp_q.size());
    end
    held_win = win;
    held_rm  = run_max;
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || win !== exp_win || run_max !== RW'(exp_rm)) begin
      errors++;
      $display("FAIL %s hold: got done=%b win=%b rm=%0d want done=0 win=%b rm=%0d", name,
               done, win, run_max, exp_win, exp_rm);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || win !== held_win || run_max !== held_rm) begin
      errors++;
      $display("FAIL %s idle_after: got busy=%b win=%b want busy=0 win=%b", name, busy, win, held_win);
    end
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if (address !== 8'd0 || rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        win !== 1'b0 || run_max !== '0) begin
      errors++;
      $display("FAIL %s: got addr=%h rd_en=%b busy=%b done=%b win=%b rm=%0d want all 0", name,
               address, rd_en, busy, done, win, run_max);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; dir = 2'd0; pointer = 8'd0; chess = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_horizontal_win();
    clear_board();
    for (int c = 5; c <= 9; c++) board[3 * NSIDE + c] = 2'd1;
    run_scan(8'h37, 2'd0, 2'd1, "horiz_win", 1'b0);
  endtask

  task automatic test_edge_clip();
    clear_board();
    run_scan(8'h01, 2'd2, 2'd2, "edge_clip_diag", 1'b0);
    run_scan(8'h01, 2'd0, 2'd2, "edge_clip_horiz", 1'b0);
    run_scan(8'hFF, 2'd1, 2'd1, "edge_clip_vert", 1'b0);
  endtask

  task automatic test_corner_antidiag();
    clear_board();
    for (int i = 0; i < 5; i++) board[(15 - i) * NSIDE + i] = 2'd1;
    run_scan(8'hF0, 2'd3, 2'd1, "corner_antidiag", 1'b0);
    board[12 * NSIDE + 3] = 2'd2;
    run_scan(8'hF0, 2'd3, 2'd1, "corner_antidiag_broken", 1'b0);
  endtask

  task automatic test_broken_run();
    clear_board();
    for (int c = 0; c <= 8; c++) board[8 * NSIDE + c] = (c == 4) ? 2'd1 : 2'd2;
    run_scan(8'h84, 2'd0, 2'd2, "broken_run", 1'b0);
  endtask

  task automatic test_empty_chess();
    clear_board();
    run_scan(8'h55, 2'd1, 2'd0, "chess_zero", 1'b0);
  endtask

  task automatic test_ignore_start();
    clear_board();
    for (int r = 4; r <= 8; r++) board[r * NSIDE + 6] = 2'd2;
    run_scan(8'h66, 2'd1, 2'd2, "start_held", 1'b1);
  endtask

  task automatic test_mid_reset();
    int nreads, guard;
    clear_board();
    for (int c = 5; c <= 9; c++) board[3 * NSIDE + c] = 2'd1;
    @(posedge clk); #1;
    start = 1'b1; dir = 2'd0; pointer = 8'h37; chess = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    nreads = 0;
    guard  = 0;
    while (nreads < 3 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
      if (rd_en === 1'b1) nreads++;
    end
    vectors++;
    if (nreads != 3) begin
      errors++;
      $display("FAIL mid_reset_reach: got %0d reads want 3", nreads);
    end
    #1 reset = 1'b0;
    #1;
    check_all_zero("mid_reset_async");
    @(posedge clk); #1;
    check_all_zero("mid_reset_held");
    @(negedge clk);
    reset = 1'b1;
    run_scan(8'h37, 2'd0, 2'd1, "after_reset", 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] ptr;
    logic [1:0] d, c;
    int dr, dc, off, r, cc;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 256; i++) board[i] = 2'($urandom_range(0, 2));
      ptr = 8'($urandom);
      d   = 2'($urandom);
      c   = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 2));
      if ($urandom_range(0, 1) == 1 && c != 2'd0) begin
        dir_vec(d, dr, dc);
        off = int'($urandom_range(0, WIN_LEN - 1));
        for (int j = 0; j < int'(WIN_LEN); j++) begin
          r  = int'(ptr[7:4]) + (j - off) * dr;
          cc = int'(ptr[3:0]) + (j - off) * dc;
          if (on_board(r, cc)) board[r * NSIDE + cc] = c;
        end
        if ($urandom_range(0, 2) == 0) board[ptr] = 2'd3 - c;
      end
      run_scan(ptr, d, c, $sformatf("random_%0d", t), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal_win();
    test_edge_clip();
    test_corner_antidiag();
    test_broken_run();
    test_empty_chess();
    test_ignore_start();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
